// File: rtl/sigmoid_arb_pkg.sv
// Shared types and constants for the sigmoid ROM arbiter.
// Optional one-entry result cache: define SIGMOID_ARB_CACHE_EN.
package sigmoid_arb_pkg;

   localparam int SIG_AW         = 8;
   localparam int SIG_DW         = 8;
   localparam int SIG_ACCESS_LAT = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_CAPTURE,
      ST_HIT
   } arb_state_t;

endpackage

// File: rtl/sigmoid_rom_arbiter_pick.sv
// Combinational round-robin pick: the first set request at or after rr_ptr,
// wrapping modulo N (N need not be a power of two).
module rr_priority_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_vec,
   input  logic [PW-1:0] rr_ptr,
   output logic          found,
   output logic [PW-1:0] idx
);

   always_comb begin
      int cand;
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      // Scan from the far end so the candidate closest to rr_ptr is assigned last.
      for (int k = N - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (req_vec[cand[PW-1:0]]) begin
            found = 1'b1;
            idx   = cand[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/sigmoid_rom_arbiter.sv
// Round-robin arbiter sharing one registered sigmoid ROM among N_REQ requesters.
// Define SIGMOID_ARB_CACHE_EN to add a one-entry (addr, data) cache with a HIT path.
module sigmoid_rom_arbiter
   import sigmoid_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int AW    = SIG_AW,
   parameter int DW    = SIG_DW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*AW-1:0] addr,
   output logic [N_REQ-1:0]    ack,
   output logic [DW-1:0]       data,
   output logic                busy,
   output logic [AW-1:0]       rom_add,
   output logic                rom_cs,
   output logic                rom_read,
   input  logic [DW-1:0]       rom_out
);

   localparam int PW = $clog2(N_REQ);

   arb_state_t       state_reg;
   logic [PW-1:0]    rr_ptr_reg;
   logic [PW-1:0]    g_reg;
   logic [PW-1:0]    rr_ptr_next;
   logic [PW-1:0]    pick_idx;
   logic             pick_found;
   logic [N_REQ-1:0] eff_req;
   logic [AW-1:0]    addr_arr [N_REQ];
   logic [AW-1:0]    win_addr;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_addr
         assign addr_arr[gi] = addr[gi*AW +: AW];
      end
   endgenerate

   // The requester just acknowledged still holds req this cycle; mask it out.
   assign eff_req     = req & ~ack;
   assign win_addr    = addr_arr[pick_idx];
   assign rr_ptr_next = (g_reg == PW'(N_REQ - 1)) ? '0 : g_reg + PW'(1);

   rr_priority_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_pick (
      .req_vec (eff_req),
      .rr_ptr  (rr_ptr_reg),
      .found   (pick_found),
      .idx     (pick_idx)
   );

`ifdef SIGMOID_ARB_CACHE_EN
   logic          cache_valid_reg;
   logic [AW-1:0] cache_addr_reg;
   logic [DW-1:0] cache_data_reg;
   logic          cache_hit;

   assign cache_hit = cache_valid_reg && (cache_addr_reg == win_addr);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         rr_ptr_reg <= '0;
         g_reg      <= '0;
         ack        <= '0;
         data       <= '0;
         busy       <= 1'b0;
         rom_add    <= '0;
         rom_cs     <= 1'b0;
         rom_read   <= 1'b0;
`ifdef SIGMOID_ARB_CACHE_EN
         cache_valid_reg <= 1'b0;
         cache_addr_reg  <= '0;
         cache_data_reg  <= '0;
`endif
      end else begin
         ack <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (pick_found) begin
                  g_reg <= pick_idx;
                  busy  <= 1'b1;
`ifdef SIGMOID_ARB_CACHE_EN
                  if (cache_hit) begin
                     state_reg <= ST_HIT;
                  end else begin
                     rom_add   <= win_addr;
                     rom_read  <= 1'b1;
                     state_reg <= ST_SETUP;
                  end
`else
                  rom_add   <= win_addr;
                  rom_read  <= 1'b1;
                  state_reg <= ST_SETUP;
`endif
               end
            end
            ST_SETUP: begin
               rom_cs    <= 1'b1;
               state_reg <= ST_STROBE;
            end
            ST_STROBE: begin
               rom_cs    <= 1'b0;
               state_reg <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               data       <= rom_out;
               ack[g_reg] <= 1'b1;
               rom_read   <= 1'b0;
               rr_ptr_reg <= rr_ptr_next;
               busy       <= 1'b0;
               state_reg  <= ST_IDLE;
`ifdef SIGMOID_ARB_CACHE_EN
               cache_valid_reg <= 1'b1;
               cache_addr_reg  <= rom_add;
               cache_data_reg  <= rom_out;
`endif
            end
`ifdef SIGMOID_ARB_CACHE_EN
            ST_HIT: begin
               data       <= cache_data_reg;
               ack[g_reg] <= 1'b1;
               rr_ptr_reg <= rr_ptr_next;
               busy       <= 1'b0;
               state_reg  <= ST_IDLE;
            end
`endif
            default: begin
               rom_cs    <= 1'b0;
               rom_read  <= 1'b0;
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sigmoid_rom_arbiter.sv
// Self-checking bench for sigmoid_rom_arbiter: directed scenarios plus random
// request batches checked against a transaction-level round-robin/cache model.
`timescale 1ns/1ps
module tb_sigmoid_rom_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*8-1:0] addr = '0;
   logic [N-1:0]   ack;
   logic [7:0]     data;
   logic           busy;
   logic [7:0]     rom_add;
   logic           rom_cs;
   logic           rom_read;
   logic [7:0]     rom_out = '0;

   int   n_checks = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   int   cs_count = 0;
   logic prev_cs = 1'b0;

   // reference model state
   int         ptr_m = 0;
   bit         cvalid_m = 1'b0;
   logic [7:0] caddr_m = '0;

   always #5 clk = ~clk;

   sigmoid_rom_arbiter #(.N_REQ(N), .AW(8), .DW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .addr     (addr),
      .ack      (ack),
      .data     (data),
      .busy     (busy),
      .rom_add  (rom_add),
      .rom_cs   (rom_cs),
      .rom_read (rom_read),
      .rom_out  (rom_out)
   );

   // Behavioural ROM: sigmoid table modelled as 255 - address, latched on rom_cs rise.
   always @(posedge rom_cs) begin
      cs_count <= cs_count + 1;
      if (rom_read) rom_out <= 8'd255 - rom_add;
   end

   task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // rom_cs must be a single-clock pulse, always with rom_read high.
   always @(negedge clk) begin
      if (rom_cs) begin
         check(32'(prev_cs), 32'd0, "cs_one_clock");
         check(32'(rom_read), 32'd1, "read_during_cs");
      end
      prev_cs <= rom_cs;
   end

   function automatic int pick(input logic [N-1:0] pend, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (|(pend & (N'(1) << ((ptr + k) % N)))) return (ptr + k) % N;
      end
      return 0;
   endfunction

   task automatic predict(input logic [N-1:0] pend, output int w, output logic [7:0] a, output bit hit);
      w   = pick(pend, ptr_m);
      a   = 8'(addr >> (w * 8));
      hit = 1'b0;
`ifdef SIGMOID_ARB_CACHE_EN
      hit = cvalid_m && (caddr_m == a);
`endif
   endtask

   task automatic commit(input int w, input logic [7:0] a, input bit hit);
      ptr_m = (w + 1) % N;
      if (!hit) begin
         cvalid_m = 1'b1;
         caddr_m  = a;
      end
   endtask

   // Wait (bounded) for the next ack and compare winner, data, latency and ROM strobes.
   task automatic expect_ack(input int w, input logic [7:0] d, input int lat, input int cs_exp, input string tag);
      int cyc;
      int cs0;
      cyc = 0;
      cs0 = cs_count;
      do begin
         @(negedge clk);
         cyc++;
         if (ack == '0 && cyc < lat) check(32'(busy), 32'd1, {tag, "_busy"});
      end while (ack == '0 && cyc < 20);
      check(32'(ack), 32'd1 << w, {tag, "_ack"});
      check(32'(data), 32'(d), {tag, "_data"});
      check(32'(cyc), 32'(lat), {tag, "_latency"});
      check(32'(cs_count - cs0), 32'(cs_exp), {tag, "_rom_strobes"});
      $display("tx %s: expect requester %0d data %0d in %0d cycles, saw ack %b data %0d after %0d cycles",
               tag, w, d, lat, ack, data, cyc);
   endtask

   task automatic run_batch(input logic [N-1:0] rq, input logic [N*8-1:0] av,
                            input logic [N-1:0] sticky, input int n_tx, input string tag);
      logic [N-1:0] pend;
      logic [7:0]   a;
      int           w;
      bit           hit;
      @(negedge clk);
      addr = av;
      req  = rq;
      pend = rq;
      for (int t = 0; t < n_tx; t++) begin
         predict(pend, w, a, hit);
         expect_ack(w, 8'd255 - a, hit ? 2 : 4, hit ? 0 : 1, tag);
         commit(w, a, hit);
         if (t == n_tx - 1) begin
            req = '0;
         end else if (((sticky >> w) & 1) == 0) begin
            pend = pend & ~(N'(1) << w);
            @(posedge clk);
            #1;
            req = pend;
         end
      end
      @(negedge clk);
      check(32'(ack), 32'd0, {tag, "_no_extra_ack"});
      check(32'(busy), 32'd0, {tag, "_idle_after"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [N-1:0]   rq;
      logic [N*8-1:0] av;
      logic [7:0]     a;
      int             w;
      bit             hit;

      // Reset values
      repeat (3) @(negedge clk);
      check(32'(ack), 32'd0, "reset_ack");
      check(32'(data), 32'd0, "reset_data");
      check(32'(busy), 32'd0, "reset_busy");
      check(32'(rom_add), 32'd0, "reset_rom_add");
      check(32'(rom_cs), 32'd0, "reset_rom_cs");
      check(32'(rom_read), 32'd0, "reset_rom_read");
      rst_n = 1'b1;

      // All four together: order 0,1,2,3, data 255,191,127,63
      run_batch(4'b1111, {8'd192, 8'd128, 8'd64, 8'd0}, 4'b0000, 4, "all_four");

      // Single misses
      run_batch(4'b0001, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000, 1, "single_a0");
      run_batch(4'b0001, {8'd0, 8'd0, 8'd0, 8'd200}, 4'b0000, 1, "single_a200");

      // Fairness: requesters 1 and 3 keep re-requesting
      run_batch(4'b1010, {8'd33, 8'd0, 8'd77, 8'd0}, 4'b1010, 6, "fairness");

      // Requester drops req (and changes addr) during SETUP
      @(negedge clk);
      addr = {8'd40, 8'd30, 8'd20, 8'd10};
      req  = 4'b1100;
      predict(4'b1100, w, a, hit);
      @(posedge clk);
      #1;
      req  = req & ~(N'(1) << w);
      addr = addr ^ (32'h000000ff << (w * 8));
      expect_ack(w, 8'd255 - a, hit ? 2 : 4, hit ? 0 : 1, "drop_early");
      commit(w, a, hit);
      predict(req, w, a, hit);
      expect_ack(w, 8'd255 - a, hit ? 2 : 4, hit ? 0 : 1, "after_drop");
      commit(w, a, hit);
      req = '0;
      @(negedge clk);
      check(32'(ack), 32'd0, "after_drop_quiet");

      // Same address from two requesters back to back
      run_batch(4'b0011, {8'd0, 8'd0, 8'd100, 8'd100}, 4'b0000, 2, "cache_pair");

      // Reset during STROBE
      @(negedge clk);
      addr = {8'd0, 8'd0, 8'd0, 8'd77};
      req  = 4'b0001;
      @(posedge clk);
      @(posedge clk);
      #1;
      check(32'(rom_cs), 32'd1, "strobe_before_reset");
      rst_n = 1'b0;
      #1;
      check(32'(ack), 32'd0, "midrst_ack");
      check(32'(data), 32'd0, "midrst_data");
      check(32'(busy), 32'd0, "midrst_busy");
      check(32'(rom_add), 32'd0, "midrst_rom_add");
      check(32'(rom_cs), 32'd0, "midrst_rom_cs");
      check(32'(rom_read), 32'd0, "midrst_rom_read");
      req = '0;
      repeat (3) begin
         @(negedge clk);
         check(32'(ack), 32'd0, "midrst_no_ack");
      end
      rst_n    = 1'b1;
      ptr_m    = 0;
      cvalid_m = 1'b0;
      run_batch(4'b1010, {8'd9, 8'd0, 8'd5, 8'd0}, 4'b0000, 2, "post_reset");

      // Random batches over a small address set so repeats occur
      for (int b = 0; b < 20; b++) begin
         rq = N'($urandom_range(1, (1 << N) - 1));
         av = '0;
         for (int i = 0; i < N; i++) begin
            av = (av << 8) | (N*8)'($urandom_range(0, 3) * 60);
         end
         run_batch(rq, av, 4'b0000, $countones(rq), "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sigmoid_rom_arbiter.md
# sigmoid_rom_arbiter

Shares one sigmoid lookup ROM (8-bit address in, 8-bit registered activation out, strobe-on-`CS` rising edge, `read` gating) among `N_REQ` neuron requesters. The block arbitrates round-robin, drives the ROM address, `read` and `CS` strobe sequence, captures the ROM output and returns it to the winner with a one-cycle acknowledge. It sits between the neuron-layer processing elements and the single activation ROM instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `AW`, default 8: ROM address width. Fixed to 8 in this release.
- `DW`, default 8: ROM data width. Fixed to 8 in this release.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: per-requester request level, held until `ack`.
- `addr` in `N_REQ*AW`: per-requester ROM address. Slice i is `[i*AW +: AW]`.
- `ack` out `N_REQ`: one-cycle pulse to the served requester. One-hot or zero.
- `data` out `DW`: activation result. Valid in the `ack` cycle and held until the next `ack`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `rom_add` out `AW`: ROM address.
- `rom_cs` out 1: ROM strobe. The ROM latches on its rising edge.
- `rom_read` out 1: ROM read enable.
- `rom_out` in `DW`: ROM registered output.

## Operation
- States are IDLE, SETUP, STROBE and CAPTURE (plus HIT when `SIGMOID_ARB_CACHE_EN` is defined).
- **IDLE:** the effective request is `req & ~ack`. If it is nonzero:
  - Pick the first set bit at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - Latch the winner index `g` and `rom_add <= addr[g]`.
  - Set `rom_read <= 1`.
  - Go to SETUP.
- **SETUP:** `rom_cs <= 1`, go to STROBE. The address and `read` have been stable for one cycle before the strobe edge.
- **STROBE:** `rom_cs <= 0`, go to CAPTURE. The ROM output settles during this cycle.
- **CAPTURE:**
  - `data <= rom_out` and `ack[g] <= 1` for one cycle.
  - `rom_read <= 0`.
  - `rr_ptr <= (g+1) mod N_REQ`.
  - Go to IDLE.
- The address is sampled only at grant. Later changes to `addr[g]` have no effect on that transaction.
- If `req[g]` drops mid-transaction, the transaction still completes, `ack[g]` still pulses and `data` still updates.
- Requesters deassert `req` in the cycle after seeing `ack`. Masking with `~ack` prevents a double grant. A requester may re-request immediately and is then served after the others, per round-robin.
- `rr_ptr` is `$clog2(N_REQ)` bits. Wrap from `N_REQ-1` goes to 0, including for non-power-of-two `N_REQ`.

## Timing
- **Reset values:** `ack=0`, `data=0`, `busy=0`, `rom_add=0`, `rom_cs=0`, `rom_read=0`, state IDLE, `rr_ptr=0`.
- **Reset mid-operation:** everything returns to the reset values immediately. No `ack` is issued for the aborted transaction. `rom_cs` drops to 0, so no spurious ROM strobe occurs.
- **Latency:** `req` is sampled high in IDLE at cycle 0, `rom_cs` is high in cycle 2, and `ack`/`data` appear in cycle 4. This gives 4 cycles per miss.
- **Throughput:** one lookup per 4 cycles. Back-to-back grants are possible because CAPTURE returns to IDLE, and IDLE arbitrates again in the cycle `ack` is high.
- **Simultaneous requests:** served strictly in round-robin order starting at `rr_ptr`. No requester waits more than `N_REQ-1` transactions.
- `rom_cs` is high for exactly one clock per ROM access.
- `rom_read` is high from SETUP through STROBE.

## Configuration
- **`SIGMOID_ARB_CACHE_EN` defined:**
  - A one-entry cache holds the last looked-up `(addr, data)` pair, with a valid bit cleared by reset.
  - In IDLE, if the winner's address equals the cached address and the valid bit is set, the FSM goes to HIT instead of SETUP.
  - HIT drives `ack[g]=1` with `data` = cached value, advances `rr_ptr`, and makes no ROM access (`rom_cs`/`rom_read` stay 0).
  - Hit latency is 2 cycles from the `req` sample.
  - Every CAPTURE updates the cache.
- **`SIGMOID_ARB_CACHE_EN` undefined:** no cache logic and no HIT state. Every request costs 4 cycles.

## Structure
- Package `sigmoid_arb_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, CAPTURE, HIT);
  - constants `SIG_AW=8`, `SIG_DW=8` and `SIG_ACCESS_LAT=4`.
- Sub-module `rr_priority_pick`: combinational round-robin pick. Inputs are the request vector and `rr_ptr`; outputs are `found` and the winner index. It is instantiated once.
- FSM, cache and output registers live in `sigmoid_rom_arbiter`.

## Test plan
- **Single request, miss:** reset, then `req[0]=1` with `addr0=0`. Expect `rom_cs` high in cycle 2 only, `ack[0]` in cycle 4, `data=255`. Then with `addr0=200`, expect `data=55`.
- **All four request together:** `addr` = 0, 64, 128, 192. Expect `ack` order 0, 1, 2, 3 with `data` 255, 191, 127, 63, `ack` spaced 4 cycles apart, and `busy` continuous.
- **Fairness:** `req[1]` held permanently (re-requesting after each `ack`) while `req[3]` also requests. Expect alternating acks 1, 3, 1, 3 and no starvation.
- **Reset mid-operation:** assert `rst_n=0` during STROBE. Expect all outputs 0 at once, no `ack`, and `rr_ptr=0`. After release, a fresh request completes in 4 cycles.
- **Requester drops early:** `req[2]` drops during SETUP. Expect `ack[2]` still pulsed with the correct data, and the next grant goes to the next requester.
- **Cache:** two back-to-back requests to address 100 from requesters 0 and 1. With `SIGMOID_ARB_CACHE_EN`, expect the second ack 2 cycles after its grant with `data=155` and no `rom_cs` pulse. Without the macro, expect 4 cycles and a `rom_cs` pulse.
